// File: rtl/load_store_unit.sv
// Load/store unit bridging RISC-V byte/half/word requests onto a word-wide data memory.
// Sub-word stores are handled as read-modify-write; malformed requests never reach memory.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        req_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'h0, b};
      3'b101:  res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3,
                                              input logic [31:0] wd);
    logic [31:0] res;
    res = word;
    case (f3)
      3'b000: res[{lane, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (lane[1]) res[31:16] = wd[15:0];
        else         res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'b010) req_err = 1'b1;
    end else if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS)             req_err = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          we_d        = req_we;
          funct3_d    = req_funct3;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && req_funct3 == 3'b010) begin
            state_d    = WRITE;
            mem_we_d   = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
            mem_wd_d   = req_wdata;
          end else begin
            state_d    = READ;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      READ: begin
        // Outputs are registered, so the merged store word is formed from mem_rdata here
        // and presented during WRITE without a separate capture register.
        if (we_q) begin
          state_d  = WRITE;
          mem_we_d = 1'b1;
          mem_wd_d = store_merge(mem_rdata, addr_q[1:0], funct3_q, wdata_q);
        end else begin
          state_d      = RESP;
          mem_addr_d   = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extract(mem_rdata, addr_q[1:0], funct3_q);
        end
      end
      WRITE: begin
        state_d      = RESP;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wd_d     = '0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign mem_funct3 = 3'b010;

endmodule
